// File: rtl/axi_wr_slave.sv
// AXI3 write-channel slave: accepts one AW burst at a time, turns each W beat
// into a single registered byte-enabled write on a simple memory port.
module axi_wr_slave #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int MEM_AW = 16
) (
   input  logic              aclk,
   input  logic              arst,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [3:0]        awid,
   input  logic [3:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [3:0]        wid,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [3:0]        bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_be
);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_awready;
   logic              r_wready;
   logic              r_bvalid;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_id;
   logic [3:0]        r_len;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic [3:0]        r_beatCnt;
   logic              r_err;
   logic              r_noWrite;
   logic              r_memWe;
   logic [MEM_AW-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memWdata;
   logic [7:0]        r_memBe;

   logic              w_awHs;
   logic              w_wHs;
   logic              w_bHs;
   logic              w_lastBeat;
   logic              w_awErr;
   logic              w_beatErr;
   logic [ADDR_W-1:0] w_incr;
   logic [ADDR_W-1:0] w_wrapMask;
   logic [ADDR_W-1:0] w_nextAddr;
   logic [7:0]        w_expStrb;
   logic [7:0]        w_laneMask;

   assign w_awHs     = awvalid && r_awready;
   assign w_wHs      = wvalid && r_wready;
   assign w_bHs      = r_bvalid && bready;
   assign w_lastBeat = (r_beatCnt == r_len);

   // Burst-shape errors are known at AW time and suppress every write of the burst.
   assign w_awErr = (awburst == 2'b11) || (awsize > 3'd3) ||
                    ((awburst == 2'b10) && !((awlen == 4'd1) || (awlen == 4'd3) ||
                                             (awlen == 4'd7) || (awlen == 4'd15)));
   assign w_beatErr = (wid != r_id) || (wlast != w_lastBeat);

   assign w_incr     = ADDR_W'(1) << r_size;
   assign w_wrapMask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

   always_comb begin
      w_nextAddr = r_addr + w_incr;
      case (r_burst)
         2'b00:   w_nextAddr = r_addr;
         2'b10:   w_nextAddr = (r_addr & ~w_wrapMask) | ((r_addr + w_incr) & w_wrapMask);
         default: w_nextAddr = r_addr + w_incr;
      endcase
   end

   // Narrow beats only touch the size-aligned container that holds the beat address.
   always_comb begin
      w_expStrb  = {{2{wstrb[3]}}, {2{wstrb[2]}}, {2{wstrb[1]}}, {2{wstrb[0]}}};
      w_laneMask = 8'hFF;
      case (r_size)
         3'd0:    w_laneMask = 8'h01 << r_addr[2:0];
         3'd1:    w_laneMask = 8'h03 << {r_addr[2:1], 1'b0};
         3'd2:    w_laneMask = 8'h0F << {r_addr[2], 2'b00};
         default: w_laneMask = 8'hFF;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_awHs) w_next = DATA;
         DATA:    if (w_wHs && w_lastBeat) w_next = RESP;
         RESP:    if (w_bHs) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they drop to 0 in
   // reset and come up one cycle after release.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_state   <= IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_awready <= (w_next == IDLE);
         r_wready  <= (w_next == DATA);
         r_bvalid  <= (w_next == RESP);
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_addr    <= '0;
         r_id      <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_beatCnt <= '0;
         r_err     <= 1'b0;
         r_noWrite <= 1'b0;
      end else if (w_awHs) begin
         r_addr    <= awaddr;
         r_id      <= awid;
         r_len     <= awlen;
         r_size    <= awsize;
         r_burst   <= awburst;
         r_beatCnt <= '0;
         r_err     <= w_awErr;
         r_noWrite <= w_awErr;
      end else if (w_wHs) begin
         r_addr    <= w_nextAddr;
         r_beatCnt <= r_beatCnt + 4'd1;
         if (w_beatErr) r_err <= 1'b1;
      end
   end

   // One-cycle write pipeline; data fields only update on an accepted beat.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_memBe    <= '0;
      end else begin
         r_memWe <= w_wHs && !r_noWrite;
         if (w_wHs) begin
            r_memAddr  <= r_addr[MEM_AW+2:3];
            r_memWdata <= wdata;
            r_memBe    <= w_expStrb & w_laneMask;
         end
      end
   end

   assign awready   = r_awready;
   assign wready    = r_wready;
   assign bvalid    = r_bvalid;
   assign bid       = r_id;
   assign bresp     = (r_bvalid && r_err) ? 2'b10 : 2'b00;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign mem_be    = r_memBe;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed self-checking bench for axi_wr_slave: INCR, WRAP, FIXED, narrow,
// error, backpressure and mid-burst reset scenarios with hand-computed values.
module tb_axi_wr_slave;

   logic        aclk;
   logic        arst;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [63:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;

   int nChecks = 0;
   int nPass   = 0;

   axi_wr_slave #(.ADDR_W(32), .DATA_W(64), .MEM_AW(16)) dut (
      .aclk      (aclk),
      .arst      (arst),
      .awaddr    (awaddr),
      .awid      (awid),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wid       (wid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_awready"}, 64'(awready), 64'(0));
      check({tag, "_wready"}, 64'(wready), 64'(0));
      check({tag, "_bvalid"}, 64'(bvalid), 64'(0));
      check({tag, "_bresp"}, 64'(bresp), 64'(0));
      check({tag, "_bid"}, 64'(bid), 64'(0));
      check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      check({tag, "_mem_wdata"}, mem_wdata, 64'(0));
      check({tag, "_mem_be"}, 64'(mem_be), 64'(0));
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
      awaddr  = addr;
      awid    = id;
      awlen   = len;
      awsize  = size;
      awburst = burst;
      awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      check("aw_accept_awready", 64'(awready), 64'(0));
      check("aw_accept_wready", 64'(wready), 64'(1));
   endtask

   task automatic sendBeat(input logic [63:0] data, input logic [3:0] strb, input logic [3:0] id,
                           input logic last, input logic expWe, input logic [15:0] expAddr,
                           input logic [7:0] expBe);
      wdata  = data;
      wstrb  = strb;
      wid    = id;
      wlast  = last;
      wvalid = 1'b1;
      @(posedge aclk); #1;
      check("beat_mem_we", 64'(mem_we), 64'(expWe));
      if (expWe) begin
         check("beat_mem_addr", 64'(mem_addr), 64'(expAddr));
         check("beat_mem_be", 64'(mem_be), 64'(expBe));
         check("beat_mem_wdata", mem_wdata, data);
      end
   endtask

   task automatic endData;
      wvalid = 1'b0;
      wlast  = 1'b0;
      check("end_wready", 64'(wready), 64'(0));
      check("end_bvalid", 64'(bvalid), 64'(1));
   endtask

   task automatic checkOutput(input logic [3:0] expId, input logic [1:0] expResp);
      check("resp_bvalid", 64'(bvalid), 64'(1));
      check("resp_bid", 64'(bid), 64'(expId));
      check("resp_bresp", 64'(bresp), 64'(expResp));
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      check("post_resp_bvalid", 64'(bvalid), 64'(0));
      check("post_resp_awready", 64'(awready), 64'(1));
      check("post_resp_mem_we", 64'(mem_we), 64'(0));
   endtask

   initial begin
      arst    = 1'b1;
      awaddr  = '0;
      awid    = '0;
      awlen   = '0;
      awsize  = '0;
      awburst = '0;
      awvalid = 1'b0;
      wid     = '0;
      wdata   = '0;
      wstrb   = '0;
      wlast   = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;

      repeat (2) @(posedge aclk);
      #1;
      checkAllZero("reset");
      arst = 1'b0;
      @(posedge aclk); #1;
      check("release_awready", 64'(awready), 64'(1));
      check("release_wready", 64'(wready), 64'(0));

      $display("[TB] INCR burst");
      applyStimulus(32'h100, 4'h5, 4'd3, 3'd3, 2'b01);
      sendBeat(64'd1, 4'hF, 4'h5, 1'b0, 1'b1, 16'h20, 8'hFF);
      sendBeat(64'd2, 4'hF, 4'h5, 1'b0, 1'b1, 16'h21, 8'hFF);
      sendBeat(64'd3, 4'hF, 4'h5, 1'b0, 1'b1, 16'h22, 8'hFF);
      sendBeat(64'd4, 4'hF, 4'h5, 1'b1, 1'b1, 16'h23, 8'hFF);
      endData();
      checkOutput(4'h5, 2'b00);

      $display("[TB] WRAP burst");
      applyStimulus(32'h118, 4'h3, 4'd3, 3'd3, 2'b10);
      sendBeat(64'hA0, 4'hF, 4'h3, 1'b0, 1'b1, 16'h23, 8'hFF);
      sendBeat(64'hA1, 4'hF, 4'h3, 1'b0, 1'b1, 16'h20, 8'hFF);
      sendBeat(64'hA2, 4'hF, 4'h3, 1'b0, 1'b1, 16'h21, 8'hFF);
      sendBeat(64'hA3, 4'hF, 4'h3, 1'b1, 1'b1, 16'h22, 8'hFF);
      endData();
      checkOutput(4'h3, 2'b00);

      $display("[TB] FIXED burst with partial strobe");
      applyStimulus(32'h40, 4'h7, 4'd1, 3'd3, 2'b00);
      sendBeat(64'h1111_2222_3333_4444, 4'h5, 4'h7, 1'b0, 1'b1, 16'h08, 8'h33);
      sendBeat(64'h5555_6666_7777_8888, 4'h5, 4'h7, 1'b1, 1'b1, 16'h08, 8'h33);
      endData();
      checkOutput(4'h7, 2'b00);

      $display("[TB] narrow INCR burst");
      applyStimulus(32'h302, 4'h2, 4'd1, 3'd1, 2'b01);
      sendBeat(64'hBEEF, 4'hF, 4'h2, 1'b0, 1'b1, 16'h60, 8'h0C);
      sendBeat(64'hCAFE, 4'hF, 4'h2, 1'b1, 1'b1, 16'h60, 8'h30);
      endData();
      checkOutput(4'h2, 2'b00);

      $display("[TB] early wlast");
      applyStimulus(32'h200, 4'hA, 4'd2, 3'd3, 2'b01);
      sendBeat(64'h10, 4'hF, 4'hA, 1'b0, 1'b1, 16'h40, 8'hFF);
      sendBeat(64'h11, 4'hF, 4'hA, 1'b1, 1'b1, 16'h41, 8'hFF);
      sendBeat(64'h12, 4'hF, 4'hA, 1'b1, 1'b1, 16'h42, 8'hFF);
      endData();
      checkOutput(4'hA, 2'b10);

      $display("[TB] reserved burst type");
      applyStimulus(32'h80, 4'h4, 4'd1, 3'd3, 2'b11);
      sendBeat(64'h20, 4'hF, 4'h4, 1'b0, 1'b0, 16'h0, 8'h0);
      sendBeat(64'h21, 4'hF, 4'h4, 1'b1, 1'b0, 16'h0, 8'h0);
      endData();
      checkOutput(4'h4, 2'b10);

      $display("[TB] bad WRAP length");
      applyStimulus(32'h0, 4'h6, 4'd2, 3'd3, 2'b10);
      sendBeat(64'h30, 4'hF, 4'h6, 1'b0, 1'b0, 16'h0, 8'h0);
      sendBeat(64'h31, 4'hF, 4'h6, 1'b0, 1'b0, 16'h0, 8'h0);
      sendBeat(64'h32, 4'hF, 4'h6, 1'b1, 1'b0, 16'h0, 8'h0);
      endData();
      checkOutput(4'h6, 2'b10);

      $display("[TB] wid mismatch with response backpressure");
      applyStimulus(32'h500, 4'hC, 4'd0, 3'd3, 2'b01);
      sendBeat(64'h99, 4'hF, 4'h1, 1'b1, 1'b1, 16'hA0, 8'hFF);
      endData();
      awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", 64'(bvalid), 64'(1));
         check("bp_bid", 64'(bid), 64'(4'hC));
         check("bp_bresp", 64'(bresp), 64'(2'b10));
         check("bp_awready", 64'(awready), 64'(0));
         @(posedge aclk); #1;
      end
      awvalid = 1'b0;
      checkOutput(4'hC, 2'b10);

      $display("[TB] reset mid-burst");
      applyStimulus(32'h0, 4'h9, 4'd7, 3'd3, 2'b01);
      sendBeat(64'h40, 4'hF, 4'h9, 1'b0, 1'b1, 16'h00, 8'hFF);
      sendBeat(64'h41, 4'hF, 4'h9, 1'b0, 1'b1, 16'h01, 8'hFF);
      arst = 1'b1;
      #1;
      checkAllZero("midreset");
      wvalid = 1'b0;
      @(posedge aclk); #1;
      arst = 1'b0;
      @(posedge aclk); #1;
      check("midreset_release_awready", 64'(awready), 64'(1));
      check("midreset_release_bvalid", 64'(bvalid), 64'(0));
      check("midreset_release_mem_we", 64'(mem_we), 64'(0));
      repeat (3) @(posedge aclk);
      #1;
      check("midreset_idle_bvalid", 64'(bvalid), 64'(0));
      check("midreset_idle_mem_we", 64'(mem_we), 64'(0));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
AXI3 write-channel slave that consumes the AW, W and B channels of the team's AXI bus interface. It converts accepted bursts into single-beat byte-enabled writes on a simple memory port. It is the downstream endpoint for the master driver and is used as the write side of the AXI memory model and DUT stubs.
Supports FIXED, INCR and WRAP bursts, one outstanding transaction, and full BRESP error reporting.

Parameters:
ADDR_W, 32, AXI byte-address width
DATA_W, 64, data width in bits (fixed 64 in this revision)
MEM_AW, 16, memory word-address width (8-byte words)

Ports:
aclk  in  1  clock, all logic on rising edge
arst  in  1  asynchronous active-high reset
awaddr  in  32  burst start byte address
awid  in  4  write transaction ID
awlen  in  4  beats minus 1 (1..16 beats)
awsize  in  3  bytes per beat = 2^awsize
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  address valid
awready  out  1  address accepted
wid  in  4  write data ID
wdata  in  64  write data
wstrb  in  4  strobe; bit i enables bytes 2i and 2i+1
wlast  in  1  last beat marker
wvalid  in  1  data valid
wready  out  1  data accepted
bid  out  4  response ID (= captured awid)
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  response valid
bready  in  1  response accepted
mem_we  out  1  memory write strobe, one cycle per beat
mem_addr  out  MEM_AW  word address = beat_addr[MEM_AW+2:3]
mem_wdata  out  64  registered wdata
mem_be  out  8  byte enables expanded from wstrb

Behaviour:
- Reset (arst high, async): state IDLE. awready=0, wready=0, bvalid=0, bresp=00, bid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. First cycle after release: awready=1.
- FSM has three states: IDLE, DATA, RESP.
- IDLE:
  - awready=1, wready=0.
  - On awvalid&&awready, capture addr, id, len, size and burst; clear beat_cnt and err; go to DATA.
  - No W beat is accepted in IDLE.
- DATA:
  - awready=0, wready=1.
  - On each wvalid&&wready, the next cycle drives mem_we=1 with mem_addr, mem_wdata and mem_be for that beat. Latency is 1 cycle. mem_we is low on non-handshake cycles.
  - Back-to-back beats give one write per cycle.
- Address advance after each beat:
  - FIXED: address unchanged.
  - INCR and reserved: addr += 2^size.
  - WRAP: boundary = (len+1)*2^size. addr = (addr & ~(boundary-1)) | ((addr+2^size) & (boundary-1)).
- Sub-word beats (size<3): mem_be is masked to the byte lanes addressed by addr[2:0] and size, ANDed with the expanded wstrb.
- Set err (final bresp=10) on any of:
  - burst==11
  - size>3
  - WRAP with len not in {1,3,7,15}
  - wid != captured id on any beat
  - wlast=1 before beat_cnt==len
  - wlast=0 on beat_cnt==len
- Errors from burst, size or WRAP length are known at AW capture. In those cases mem_we stays 0 for the whole burst, but all len+1 beats are still accepted. wid and wlast errors do not suppress writes.
- Beat counting: 4-bit beat_cnt. The beat with beat_cnt==len is the last. Go to RESP at the next edge with wready=0. Beats are counted by handshake only, regardless of wlast.
- RESP:
  - bvalid=1, bid=captured id, bresp=err?10:00. These are held stable until bready.
  - On bvalid&&bready, go to IDLE with bvalid=0 next cycle. awready=1 again that same next cycle.
- Simultaneous events: awvalid during DATA or RESP is not accepted (awready=0). wvalid during IDLE or RESP is not accepted (wready=0).
- Reset mid-burst or mid-response abandons the transaction. No B is issued and no further mem_we occurs.

Test Plan:
- INCR: awaddr=0x100, len=3, size=3, wstrb=F, data 1..4 -> mem_we on 4 cycles at word addr 0x20..0x23 with mem_be=FF; bid=awid, bresp=00.
- WRAP: awaddr=0x118, len=3, size=3 -> word addrs 0x23, 0x20, 0x21, 0x22; bresp=00.
- FIXED plus partial strobe: awaddr=0x40, len=1, wstrb=0x5 -> two writes to word 0x08 with mem_be=0x33.
- Early wlast on beat 1 of a len=2 burst -> 3 beats written, bresp=10; reserved burst=11 -> no mem_we, bresp=10.
- Backpressure: hold bready=0 for 5 cycles -> bvalid, bid and bresp stable and awready=0 throughout; release -> awready=1 the cycle after the handshake.
- Assert arst after beat 2 of a len=7 burst -> all outputs 0 immediately, no bvalid, awready=1 after release.
